rib_slave_mux: RTL and testbench

RIB_SLAVE_MUX -- requirements
Module: rib_slave_mux

---
 rtl/rib_slave_mux.sv | 176 +++++++++++++++++
 tb/tb_rib_slave_mux.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rib_slave_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rib_slave_mux : RIB 1:N address-decoding mux with in-order response FIFO.  |
// | Option macro RIB_SLAVE_MUX_ERRSLV_EN: internal error responder on default. |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module rib_slave_mux #(
  parameter int SLAVES   = 3,
  parameter int SEL_BITS = 8,
  parameter int OT_DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [SEL_BITS*SLAVES-1:0]   i_slave_base,
  input  logic [SEL_BITS*SLAVES-1:0]   i_slave_amask,
  input  logic [31:0]                  i_ribm_addr,
  input  logic                         i_ribm_wrcs,
  input  logic [3:0]                   i_ribm_mask,
  input  logic [31:0]                  i_ribm_wdata,
  input  logic                         i_ribm_req,
  output logic                         o_ribm_gnt,
  output logic                         o_ribm_rsp,
  output logic [31:0]                  o_ribm_rdata,
  input  logic                         i_ribm_rdy,
  output logic [32*SLAVES-1:0]         o_ribs_addr,
  output logic [SLAVES-1:0]            o_ribs_wrcs,
  output logic [4*SLAVES-1:0]          o_ribs_mask,
  output logic [32*SLAVES-1:0]         o_ribs_wdata,
  output logic [SLAVES-1:0]            o_ribs_req,
  input  logic [SLAVES-1:0]            i_ribs_gnt,
  input  logic [SLAVES-1:0]            i_ribs_rsp,
  input  logic [32*SLAVES-1:0]         i_ribs_rdata,
  output logic [SLAVES-1:0]            o_ribs_rdy,
  output logic [31:0]                  o_ribd_addr,
  output logic                         o_ribd_wrcs,
  output logic [3:0]                   o_ribd_mask,
  output logic [31:0]                  o_ribd_wdata,
  output logic                         o_ribd_req,
  output logic                         o_ribd_rdy,
  input  logic                         i_ribd_gnt,
  input  logic                         i_ribd_rsp,
  input  logic [31:0]                  i_ribd_rdata,
  output logic [$clog2(OT_DEPTH):0]    o_ot_cnt
);

  localparam int             IDW    = $clog2(SLAVES + 1);
  localparam int             PW     = $clog2(OT_DEPTH);
  localparam logic [IDW-1:0] DEF_ID = IDW'(SLAVES);

  logic                def_gnt;
  logic                def_rsp;
  logic [31:0]         def_rdata;
  logic                def_ext;

`ifdef RIB_SLAVE_MUX_ERRSLV_EN
  // Error responder: always grants, always ready to answer once at the head.
  localparam logic [31:0] ERR_RDATA = 32'hBADADD00;
  logic unused_ribd;
  assign def_gnt     = 1'b1;
  assign def_rsp     = 1'b1;
  assign def_rdata   = ERR_RDATA;
  assign def_ext     = 1'b0;
  assign unused_ribd = ^{i_ribd_gnt, i_ribd_rsp, i_ribd_rdata};
`else
  assign def_gnt   = i_ribd_gnt;
  assign def_rsp   = i_ribd_rsp;
  assign def_rdata = i_ribd_rdata;
  assign def_ext   = 1'b1;
`endif

  logic [SEL_BITS-1:0] addr_hi;
  logic [IDW-1:0]      tgt;
  logic                tgt_gnt;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic [IDW-1:0]      head;
  logic                head_rsp;
  logic [31:0]         head_rdata;

  logic [IDW-1:0]      id_mem_q [OT_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW:0]         cnt_q, cnt_d;

  assign addr_hi = i_ribm_addr[31:32-SEL_BITS];
  assign full    = (cnt_q == (PW+1)'(OT_DEPTH));
  assign empty   = (cnt_q == '0);
  assign head    = id_mem_q[rd_ptr_q];

  // Descending scan so the lowest matching index is the last write and wins.
  always_comb begin
    tgt = DEF_ID;
    for (int k = SLAVES - 1; k >= 0; k--) begin
      if (((addr_hi ^ i_slave_base[k*SEL_BITS +: SEL_BITS]) &
           i_slave_amask[k*SEL_BITS +: SEL_BITS]) == '0)
        tgt = IDW'(k);
    end
  end

  always_comb begin
    tgt_gnt = def_gnt;
    for (int k = 0; k < SLAVES; k++) begin
      if (tgt == IDW'(k))
        tgt_gnt = i_ribs_gnt[k];
    end
    o_ribm_gnt = tgt_gnt & ~full;
    push       = i_ribm_req & o_ribm_gnt;
  end

  always_comb begin
    head_rsp   = def_rsp;
    head_rdata = def_rdata;
    for (int k = 0; k < SLAVES; k++) begin
      if (head == IDW'(k)) begin
        head_rsp   = i_ribs_rsp[k];
        head_rdata = i_ribs_rdata[k*32 +: 32];
      end
    end
    o_ribm_rsp   = ~empty & head_rsp;
    o_ribm_rdata = empty ? 32'h0 : head_rdata;
    pop          = o_ribm_rsp & i_ribm_rdy;
  end

  always_comb begin
    o_ribs_req = '0;
    o_ribs_rdy = '0;
    for (int k = 0; k < SLAVES; k++) begin
      o_ribs_req[k] = i_ribm_req & ~full & (tgt == IDW'(k));
      o_ribs_rdy[k] = i_ribm_rdy & ~empty & (head == IDW'(k));
    end
    o_ribd_req = def_ext & i_ribm_req & ~full & (tgt == DEF_ID);
    o_ribd_rdy = def_ext & i_ribm_rdy & ~empty & (head == DEF_ID);
  end

  for (genvar k = 0; k < SLAVES; k++) begin : g_slv_bcast
    assign o_ribs_addr[k*32 +: 32]  = {{SEL_BITS{1'b0}}, i_ribm_addr[31-SEL_BITS:0]};
    assign o_ribs_wrcs[k]           = i_ribm_wrcs;
    assign o_ribs_mask[k*4 +: 4]    = i_ribm_mask;
    assign o_ribs_wdata[k*32 +: 32] = i_ribm_wdata;
  end

  assign o_ribd_addr  = i_ribm_addr;
  assign o_ribd_wrcs  = i_ribm_wrcs;
  assign o_ribd_mask  = i_ribm_mask;
  assign o_ribd_wdata = i_ribm_wdata;

  // Push never happens when full and pop never when empty, so no clamping.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push)
      id_mem_q[wr_ptr_q] <= tgt;
  end

  assign o_ot_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rib_slave_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rib_slave_mux : self-checking bench for rib_slave_mux (3 slaves, OT=4). |
// | Revision 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_rib_slave_mux;

  localparam int SLAVES   = 3;
  localparam int SEL_BITS = 8;
  localparam int OT_DEPTH = 4;
`ifdef RIB_SLAVE_MUX_ERRSLV_EN
  localparam logic [31:0] DEF_RDATA = 32'hBADADD00;
`else
  localparam logic [31:0] DEF_RDATA = 32'hD0D0_D0D0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] slave_base  = {8'h20, 8'h10, 8'h10};
  logic [23:0] slave_amask = {8'hFF, 8'hF0, 8'hFF};
  logic [31:0] ribm_addr;
  logic        ribm_wrcs;
  logic [3:0]  ribm_mask;
  logic [31:0] ribm_wdata;
  logic        ribm_req;
  logic        ribm_rdy;
  logic [2:0]  ribs_gnt;
  logic [2:0]  ribs_rsp;
  logic [95:0] ribs_rdata = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
  logic        ribd_gnt;
  logic        ribd_rsp;
  logic [31:0] ribd_rdata = 32'hD0D0_D0D0;

  logic        ribm_gnt, ribm_rsp;
  logic [31:0] ribm_rdata;
  logic [95:0] ribs_addr, ribs_wdata;
  logic [2:0]  ribs_wrcs, ribs_req, ribs_rdy;
  logic [11:0] ribs_mask;
  logic [31:0] ribd_addr, ribd_wdata;
  logic        ribd_wrcs, ribd_req, ribd_rdy;
  logic [3:0]  ribd_mask;
  logic [2:0]  ot_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] sb_q [$];

  always #5 clk = ~clk;

  rib_slave_mux #(.SLAVES(SLAVES), .SEL_BITS(SEL_BITS), .OT_DEPTH(OT_DEPTH)) u_dut (
    .i_clk(clk), .i_rst(rst),
    .i_slave_base(slave_base), .i_slave_amask(slave_amask),
    .i_ribm_addr(ribm_addr), .i_ribm_wrcs(ribm_wrcs), .i_ribm_mask(ribm_mask),
    .i_ribm_wdata(ribm_wdata), .i_ribm_req(ribm_req), .o_ribm_gnt(ribm_gnt),
    .o_ribm_rsp(ribm_rsp), .o_ribm_rdata(ribm_rdata), .i_ribm_rdy(ribm_rdy),
    .o_ribs_addr(ribs_addr), .o_ribs_wrcs(ribs_wrcs), .o_ribs_mask(ribs_mask),
    .o_ribs_wdata(ribs_wdata), .o_ribs_req(ribs_req), .i_ribs_gnt(ribs_gnt),
    .i_ribs_rsp(ribs_rsp), .i_ribs_rdata(ribs_rdata), .o_ribs_rdy(ribs_rdy),
    .o_ribd_addr(ribd_addr), .o_ribd_wrcs(ribd_wrcs), .o_ribd_mask(ribd_mask),
    .o_ribd_wdata(ribd_wdata), .o_ribd_req(ribd_req), .o_ribd_rdy(ribd_rdy),
    .i_ribd_gnt(ribd_gnt), .i_ribd_rsp(ribd_rsp), .i_ribd_rdata(ribd_rdata),
    .o_ot_cnt(ot_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Independent decode model: lowest matching slave, else default id 3.
  function automatic int decode(input logic [31:0] addr);
    logic [7:0] hi;
    hi = addr[31:24];
    for (int k = 0; k < SLAVES; k++)
      if (((hi ^ slave_base[k*8 +: 8]) & slave_amask[k*8 +: 8]) == 8'h0) return k;
    return SLAVES;
  endfunction

  function automatic logic [31:0] exp_rdata(input int id);
    return (id < SLAVES) ? (32'hA000_0000 + 32'(id)) : DEF_RDATA;
  endfunction

  // Scoreboard: push on accept, pop and compare on completed response.
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (ribm_rsp && ribm_rdy) begin
        if (sb_q.size() == 0) chk("sb_underflow", 32'(sb_q.size()), 32'd1);
        else chk("rdata", ribm_rdata, sb_q.pop_front());
      end
      if (ribm_req && ribm_gnt) sb_q.push_back(exp_rdata(decode(ribm_addr)));
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ribm_addr = 32'h0; ribm_wrcs = 1'b1; ribm_mask = 4'hF;
    ribm_wdata = 32'h1234_5678; ribm_req = 1'b0; ribm_rdy = 1'b1;
    ribs_gnt = 3'b111; ribs_rsp = 3'b000; ribd_gnt = 1'b0; ribd_rsp = 1'b0;
    next(); next();
    rst = 1'b0; #1;
    chk("rst_cnt", 32'(ot_cnt), 32'd0);
    chk("rst_rsp", 32'(ribm_rsp), 32'd0);
    chk("rst_rdy", 32'(ribs_rdy), 32'd0);

    // Decode and overlap: slaves 0 and 1 both match 0x10.
    next(); ribm_req = 1'b1; ribm_addr = 32'h1000_0040; #1;
    chk("dec_req", 32'(ribs_req), 32'b001);
    chk("dec_addr", ribs_addr[31:0], 32'h0000_0040);
    chk("dec_wdata", ribs_wdata[95:64], 32'h1234_5678);
    chk("dec_ribd_req", 32'(ribd_req), 32'd0);
    chk("dec_gnt", 32'(ribm_gnt), 32'd1);
    next(); ribm_req = 1'b0; ribs_rsp = 3'b001; #1;
    chk("dec_rsp", 32'(ribm_rsp), 32'd1);
    chk("dec_rdy", 32'(ribs_rdy), 32'b001);
    chk("dec_cnt", 32'(ot_cnt), 32'd1);
    next(); ribs_rsp = 3'b000; #1;
    chk("dec_cnt0", 32'(ot_cnt), 32'd0);

    // Ordering: slave 2 answers early and must wait behind slave 1.
    next(); ribm_req = 1'b1; ribm_addr = 32'h1100_0000; #1;
    chk("ord_req1", 32'(ribs_req), 32'b010);
    next(); ribm_addr = 32'h2000_0000; #1;
    chk("ord_req2", 32'(ribs_req), 32'b100);
    chk("ord_cnt1", 32'(ot_cnt), 32'd1);
    next(); ribm_req = 1'b0; ribs_rsp = 3'b100; #1;
    chk("ord_ignored", 32'(ribm_rsp), 32'd0);
    chk("ord_rdy1", 32'(ribs_rdy), 32'b010);
    chk("ord_cnt2", 32'(ot_cnt), 32'd2);
    next(); ribs_rsp = 3'b110; #1;
    chk("ord_rsp1", 32'(ribm_rsp), 32'd1);
    next(); ribs_rsp = 3'b100; #1;
    chk("ord_rsp2", 32'(ribm_rsp), 32'd1);
    chk("ord_rdy2", 32'(ribs_rdy), 32'b100);
    next(); ribs_rsp = 3'b000; #1;
    chk("ord_cnt0", 32'(ot_cnt), 32'd0);

    // Outstanding limit, no-bypass, simultaneous push/pop, backpressure.
    ribm_req = 1'b1; ribm_addr = 32'h1000_0000;
    for (int i = 0; i < 4; i++) next();
    ribs_rsp = 3'b001; #1;
    chk("full_cnt", 32'(ot_cnt), 32'd4);
    chk("full_gnt", 32'(ribm_gnt), 32'd0);
    chk("full_req", 32'(ribs_req), 32'd0);
    chk("full_rsp", 32'(ribm_rsp), 32'd1);
    next(); #1;
    chk("regnt_cnt", 32'(ot_cnt), 32'd3);
    chk("regnt_gnt", 32'(ribm_gnt), 32'd1);
    next(); ribm_req = 1'b0; ribm_rdy = 1'b0; #1;
    chk("pushpop_cnt", 32'(ot_cnt), 32'd3);
    chk("bp_rdy", 32'(ribs_rdy), 32'd0);
    next(); #1;
    chk("bp_cnt", 32'(ot_cnt), 32'd3);
    ribm_rdy = 1'b1;
    next(); next(); next(); ribs_rsp = 3'b000; #1;
    chk("drain_cnt", 32'(ot_cnt), 32'd0);

    // Unmatched address goes to the default port or the error responder.
`ifdef RIB_SLAVE_MUX_ERRSLV_EN
    next(); ribm_req = 1'b1; ribm_addr = 32'hFF00_0000; #1;
    chk("err_ribd_req", 32'(ribd_req), 32'd0);
    chk("err_gnt", 32'(ribm_gnt), 32'd1);
    chk("err_ribs_req", 32'(ribs_req), 32'd0);
    next(); ribm_req = 1'b0; #1;
    chk("err_rsp", 32'(ribm_rsp), 32'd1);
    chk("err_ribd_rdy", 32'(ribd_rdy), 32'd0);
    next(); #1;
    chk("err_cnt0", 32'(ot_cnt), 32'd0);
`else
    next(); ribm_req = 1'b1; ribm_addr = 32'hFF00_0000; #1;
    chk("def_ribd_req", 32'(ribd_req), 32'd1);
    chk("def_addr", ribd_addr, 32'hFF00_0000);
    chk("def_gnt_low", 32'(ribm_gnt), 32'd0);
    chk("def_ribs_req", 32'(ribs_req), 32'd0);
    next(); ribd_gnt = 1'b1; #1;
    chk("def_gnt", 32'(ribm_gnt), 32'd1);
    next(); ribm_req = 1'b0; ribd_rsp = 1'b1; #1;
    chk("def_rsp", 32'(ribm_rsp), 32'd1);
    chk("def_rdy", 32'(ribd_rdy), 32'd1);
    next(); ribd_rsp = 1'b0; #1;
    chk("def_cnt0", 32'(ot_cnt), 32'd0);
`endif

    // Reset with three outstanding; the late response must be dropped.
    ribm_req = 1'b1; ribm_addr = 32'h1000_0000;
    for (int i = 0; i < 3; i++) next();
    ribm_req = 1'b0; rst = 1'b1; ribs_rsp = 3'b001; #1;
    chk("prerst_cnt", 32'(ot_cnt), 32'd3);
    next(); rst = 1'b0; #1;
    chk("postrst_cnt", 32'(ot_cnt), 32'd0);
    chk("postrst_rsp", 32'(ribm_rsp), 32'd0);
    chk("postrst_rdy", 32'(ribs_rdy), 32'd0);
    chk("postrst_rdata", ribm_rdata, 32'd0);
    next(); #1;
    chk("late_rsp", 32'(ribm_rsp), 32'd0);
    ribs_rsp = 3'b000;

    next();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
